// File: rtl/wb_trace_fifo.sv
// Writeback trace capture: arm/trigger control, timestamping, and a
// first-word-fall-through FIFO drained by a valid/ready consumer.
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int POST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [4:0]        wb_dest,
  input  logic [31:0]       wb_data,
  input  logic              arm,
  input  logic              flush,
  input  logic              trig_en,
  input  logic [4:0]        trig_dest,
  input  logic [POST_W-1:0] post_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_dest,
  output logic [31:0]       out_data,
  output logic [15:0]       out_stamp,
  output logic [PTR_W:0]    level,
  output logic [1:0]        state,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        stamp_q;
  logic [POST_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     level_q, level_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        drop_q, drop_d;

  logic [4:0]         mem_dest  [DEPTH];
  logic [31:0]        mem_data  [DEPTH];
  logic [15:0]        mem_stamp [DEPTH];

  logic qual, trig_hit, attempt, pop, full, push_ok, drop;
  logic [POST_W-1:0] cnt_inc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    qual     = wb_we && (wb_dest != 5'd0);
    trig_hit = (state_q == S_ARMED) && qual && (!trig_en || (wb_dest == trig_dest));
    // arm wins over any capture in the same cycle
    attempt  = !arm && (trig_hit || ((state_q == S_CAPTURE) && qual));
    pop      = (level_q != '0) && out_ready;
    full     = (level_q == (PTR_W+1)'(DEPTH));
    push_ok  = attempt && !flush && (!full || pop);
    drop     = attempt && !flush && full && !pop;
    cnt_inc  = cnt_q + 1'b1;

    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (arm) begin
      state_d = S_ARMED;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end else begin
      if (attempt) begin
        cnt_d   = cnt_inc;
        state_d = ((post_cnt != '0) && (cnt_inc == post_cnt)) ? S_DONE : S_CAPTURE;
      end
      if (drop) begin
        ovf_d  = 1'b1;
        drop_d = sat_inc16(drop_q);
      end
    end

    level_d = level_q;
    if (flush) level_d = '0;
    else if (push_ok && !pop) level_d = level_q + 1'b1;
    else if (!push_ok && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      stamp_q  <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      stamp_q <= stamp_q + 16'd1;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage is data-only; validity is tracked solely by level/pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_dest[wr_ptr_q]  <= wb_dest;
      mem_data[wr_ptr_q]  <= wb_data;
      mem_stamp[wr_ptr_q] <= stamp_q;
    end
  end

  assign out_valid  = (level_q != '0);
  assign out_dest   = out_valid ? mem_dest[rd_ptr_q]  : 5'd0;
  assign out_data   = out_valid ? mem_data[rd_ptr_q]  : 32'd0;
  assign out_stamp  = out_valid ? mem_stamp[rd_ptr_q] : 16'd0;
  assign level      = level_q;
  assign state      = state_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
